detector_capture_ctrl: RTL

//  Frame-level capture sequencer between the detector driver's Avalon-ST video source and the downstream video pipe.

---
 rtl/detector_capture_ctrl_if.sv | 34 +++
 rtl/detector_capture_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/detector_capture_ctrl_if.sv
// ----------------------------------------------------------------------------
// detector_capture_ctrl_if
// Stream bundle between the detector driver source, the capture sequencer and
// the downstream video pipe.
//   din_*      : Avalon-ST style source stream (no backpressure)
//   dout_*     : gated, registered stream towards the video pipe
//   dout_ready : downstream ready, observed by the sequencer only
// Modports:
//   master : environment side (drives din_*, dout_ready; observes dout_*)
//   slave  : sequencer side   (observes din_*, dout_ready; drives dout_*)
// ----------------------------------------------------------------------------
interface detector_capture_ctrl_if #(
  parameter int DW = 14
) ();
  logic          din_sop;
  logic          din_eop;
  logic          din_valid;
  logic [DW-1:0] din_data;
  logic          dout_sop;
  logic          dout_eop;
  logic          dout_valid;
  logic [DW-1:0] dout_data;
  logic          dout_ready;

  modport master (
    output din_sop, din_eop, din_valid, din_data, dout_ready,
    input  dout_sop, dout_eop, dout_valid, dout_data
  );

  modport slave (
    input  din_sop, din_eop, din_valid, din_data, dout_ready,
    output dout_sop, dout_eop, dout_valid, dout_data
  );
endinterface

// File: rtl/detector_capture_ctrl.sv
// ----------------------------------------------------------------------------
// detector_capture_ctrl
// Frame-level capture sequencer. Passes whole frames only from the detector
// stream to the video pipe under host control (start / stop / continuous /
// N-frame capture), checks frame length and flags overflow and timeout.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   ctrl_start, ctrl_stop   one-cycle host pulses
//   ctrl_mode, ctrl_frames  0 = continuous, 1 = capture ctrl_frames frames
//   cap (slave modport)     din_* in, dout_* out (1-cycle registered), dout_ready
//   busy                    sequencer not idle
//   frames_done             complete frames forwarded since last start
//   err_len/err_ovf/err_tmo sticky error flags, cleared by an accepted start
// Build option: define CAP_TIMEOUT_EN to build the input idle-timeout counter;
// otherwise err_tmo is held at 0 and ARM/RUN wait indefinitely.
// ----------------------------------------------------------------------------
module detector_capture_ctrl #(
  parameter int DW           = 14,
  parameter int FRAME_PIXELS = 110592,
  parameter int PIX_W        = 17,
  parameter int FCNT_W       = 16,
  parameter int TIMEOUT_CYC  = 1048576
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ctrl_start,
  input  logic                     ctrl_stop,
  input  logic                     ctrl_mode,
  input  logic [FCNT_W-1:0]        ctrl_frames,
  detector_capture_ctrl_if.slave   cap,
  output logic                     busy,
  output logic [FCNT_W-1:0]        frames_done,
  output logic                     err_len,
  output logic                     err_ovf,
  output logic                     err_tmo
);

  localparam logic [1:0]       ST_IDLE   = 2'd0;
  localparam logic [1:0]       ST_ARM    = 2'd1;
  localparam logic [1:0]       ST_RUN    = 2'd2;
  localparam logic [PIX_W-1:0] PIX_MAX   = {PIX_W{1'b1}};
  localparam logic [PIX_W:0]   FRAME_LEN = (PIX_W+1)'(FRAME_PIXELS);

  logic [1:0]        state_r, state_nxt_s;
  logic [PIX_W-1:0]  pix_cnt_r, pix_nxt_s;
  logic [FCNT_W-1:0] frames_done_r, frames_nxt_s;
  logic              stop_pend_r, stop_pend_nxt_s;
  logic              err_len_r, err_len_nxt_s;
  logic              err_ovf_r, err_ovf_nxt_s;
  logic              err_tmo_r, err_tmo_nxt_s;
  logic              busy_r;
  logic              dout_sop_r, dout_eop_r, dout_valid_r;
  logic [DW-1:0]     dout_data_r;
  logic              start_acc_s, fwd_s, fwd_sop_s, fwd_eop_s, eof_s;
  logic [PIX_W:0]    eof_len_s;
  logic              tmo_hit_s;

  assign start_acc_s = (state_r == ST_IDLE) && ctrl_start && !ctrl_stop;

`ifdef CAP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt_r;

  // Limit is reached on the cycle the counter would step to TIMEOUT_CYC.
  assign tmo_hit_s = (state_r != ST_IDLE) && !cap.din_valid &&
                     (idle_cnt_r == TW'(TIMEOUT_CYC - 1));

  // Input idle counter: runs only while armed/running and no beat arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt_r <= {TW{1'b0}};
    end else if ((state_r == ST_IDLE) || cap.din_valid || tmo_hit_s) begin
      idle_cnt_r <= {TW{1'b0}};
    end else begin
      idle_cnt_r <= idle_cnt_r + TW'(1);
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state, forwarding decision and status update.
  always_comb begin
    state_nxt_s     = state_r;
    pix_nxt_s       = pix_cnt_r;
    frames_nxt_s    = frames_done_r;
    stop_pend_nxt_s = stop_pend_r;
    err_len_nxt_s   = err_len_r;
    fwd_s           = 1'b0;
    fwd_sop_s       = 1'b0;
    fwd_eop_s       = 1'b0;
    eof_s           = 1'b0;
    eof_len_s       = {1'b0, pix_cnt_r} + (PIX_W+1)'(1);
    case (state_r)
      ST_IDLE: begin
        if (start_acc_s) begin
          state_nxt_s   = ST_ARM;
          pix_nxt_s     = {PIX_W{1'b0}};
          frames_nxt_s  = {FCNT_W{1'b0}};
          err_len_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        // A stop left pending by a missing-eop recovery is honoured here too.
        if (ctrl_stop || stop_pend_r) begin
          state_nxt_s = ST_IDLE;
        end else if (cap.din_valid && cap.din_sop) begin
          fwd_s     = 1'b1;
          fwd_sop_s = 1'b1;
          pix_nxt_s = (PIX_W)'(1);
          if (cap.din_eop) begin
            fwd_eop_s = 1'b1;
            eof_s     = 1'b1;
            eof_len_s = (PIX_W+1)'(1);
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_ARM;
        end
      end
      ST_RUN: begin
        if (ctrl_stop) begin
          stop_pend_nxt_s = 1'b1;
        end else begin
          stop_pend_nxt_s = stop_pend_r;
        end
        if (cap.din_valid) begin
          fwd_s = 1'b1;
          if (cap.din_sop) begin
            // New frame started inside this one: terminate it here, drop the rest.
            fwd_eop_s     = 1'b1;
            err_len_nxt_s = 1'b1;
            state_nxt_s   = ST_ARM;
          end else if (cap.din_eop) begin
            fwd_eop_s = 1'b1;
            eof_s     = 1'b1;
          end else if (pix_cnt_r != PIX_MAX) begin
            pix_nxt_s = pix_cnt_r + (PIX_W)'(1);
          end else begin
            pix_nxt_s = pix_cnt_r;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    if (eof_s) begin
      frames_nxt_s = frames_done_r + (FCNT_W)'(1);
      if (eof_len_s != FRAME_LEN) begin
        err_len_nxt_s = 1'b1;
      end else begin
        err_len_nxt_s = err_len_r;
      end
      if (stop_pend_r || ctrl_stop ||
          (ctrl_mode && (ctrl_frames != {FCNT_W{1'b0}}) && (frames_nxt_s == ctrl_frames))) begin
        state_nxt_s = ST_IDLE;
      end else begin
        state_nxt_s = ST_ARM;
      end
    end else begin
      frames_nxt_s = frames_nxt_s;
    end

    if (tmo_hit_s) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end

    if (state_nxt_s == ST_IDLE) begin
      stop_pend_nxt_s = 1'b0;
    end else begin
      stop_pend_nxt_s = stop_pend_nxt_s;
    end

    if (start_acc_s) begin
      err_ovf_nxt_s = 1'b0;
      err_tmo_nxt_s = 1'b0;
    end else begin
      err_ovf_nxt_s = err_ovf_r | (dout_valid_r & ~cap.dout_ready);
      err_tmo_nxt_s = err_tmo_r | tmo_hit_s;
    end
  end

  // State, counters, flags and the registered output stream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      pix_cnt_r     <= {PIX_W{1'b0}};
      frames_done_r <= {FCNT_W{1'b0}};
      stop_pend_r   <= 1'b0;
      err_len_r     <= 1'b0;
      err_ovf_r     <= 1'b0;
      err_tmo_r     <= 1'b0;
      busy_r        <= 1'b0;
      dout_sop_r    <= 1'b0;
      dout_eop_r    <= 1'b0;
      dout_valid_r  <= 1'b0;
      dout_data_r   <= {DW{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      pix_cnt_r     <= pix_nxt_s;
      frames_done_r <= frames_nxt_s;
      stop_pend_r   <= stop_pend_nxt_s;
      err_len_r     <= err_len_nxt_s;
      err_ovf_r     <= err_ovf_nxt_s;
      err_tmo_r     <= err_tmo_nxt_s;
      busy_r        <= (state_nxt_s != ST_IDLE);
      dout_sop_r    <= fwd_sop_s;
      dout_eop_r    <= fwd_eop_s;
      dout_valid_r  <= fwd_s;
      dout_data_r   <= cap.din_data;
    end
  end

  assign cap.dout_sop   = dout_sop_r;
  assign cap.dout_eop   = dout_eop_r;
  assign cap.dout_valid = dout_valid_r;
  assign cap.dout_data  = dout_data_r;
  assign busy           = busy_r;
  assign frames_done    = frames_done_r;
  assign err_len        = err_len_r;
  assign err_ovf        = err_ovf_r;
  assign err_tmo        = err_tmo_r;

endmodule
